// File: rtl/trap_ctrl_vec_pkg.sv
// Shared constants and types for the machine-mode trap controller.
// The optional TRAP_EDGE_IRQ_EN build switch is consumed by the top module.
package trap_pkg;

   localparam int unsigned CODE_W = 5;

   localparam int unsigned CAUSE_MSI = 3;
   localparam int unsigned CAUSE_MTI = 7;
   localparam int unsigned CAUSE_MEI = 11;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   localparam int unsigned MIE_MSIE = 3;
   localparam int unsigned MIE_MTIE = 7;
   localparam int unsigned MIE_MEIE = 11;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      COMMIT = 2'd2
   } trap_state_e;

endpackage

// File: rtl/trap_ctrl_vec_if.sv
// Trap controller bus: CSR/event inputs, pipeline handshake and trap results.
// master = trap controller, slave = core pipeline / CSR file.
interface trap_ctrl_vec_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_EXT  = 4,
   parameter int unsigned EXT_ID_W = 5
);
   logic [XLEN-1:0]     current_pc;
   logic [XLEN-1:0]     csr_mstatus;
   logic [XLEN-1:0]     csr_mie;
   logic [XLEN-1:0]     csr_mtvec;
   logic                irq_msip;
   logic                irq_mtip;
   logic [NUM_EXT-1:0]  irq_ext;
   logic                exc_valid;
   logic [4:0]          exc_code;
   logic [XLEN-1:0]     exc_tval;
   logic                mret;
   logic                trap_req;
   logic                trap_ack;
   logic                trap_taken;
   logic                mstatus_we;
   logic [XLEN-1:0]     trap_cause;
   logic [XLEN-1:0]     trap_mepc;
   logic [XLEN-1:0]     trap_mtval;
   logic [XLEN-1:0]     trap_mstatus_new;
   logic [XLEN-1:0]     trap_vector;
   logic [EXT_ID_W-1:0] ext_claim_id;
   logic [NUM_EXT-1:0]  irq_ext_complete;

   modport master (
      input  current_pc, csr_mstatus, csr_mie, csr_mtvec,
      input  irq_msip, irq_mtip, irq_ext,
      input  exc_valid, exc_code, exc_tval, mret, trap_ack,
      output trap_req, trap_taken, mstatus_we,
      output trap_cause, trap_mepc, trap_mtval, trap_mstatus_new, trap_vector,
      output ext_claim_id, irq_ext_complete
   );

   modport slave (
      output current_pc, csr_mstatus, csr_mie, csr_mtvec,
      output irq_msip, irq_mtip, irq_ext,
      output exc_valid, exc_code, exc_tval, mret, trap_ack,
      input  trap_req, trap_taken, mstatus_we,
      input  trap_cause, trap_mepc, trap_mtval, trap_mstatus_new, trap_vector,
      input  ext_claim_id, irq_ext_complete
   );
endinterface

// File: rtl/trap_ctrl_vec_prio_enc.sv
// Lowest-index-wins priority encoder over N request lines.
module trap_prio_enc #(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = 5
) (
   input  logic [N-1:0]    i_req,
   output logic            o_valid,
   output logic [ID_W-1:0] o_idx
);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      o_valid = |i_req;
      o_idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/trap_ctrl_vec.sv
// Machine-mode trap controller: arbitration, pipeline handshake, CSR results.
// Define TRAP_EDGE_IRQ_EN for edge-detected, sticky external interrupt lines.
module trap_ctrl_vec
   import trap_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_EXT  = 4,
   parameter int unsigned EXT_ID_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   trap_ctrl_vec_if.master bus
);

   logic                w_mie, w_mpie, w_msie, w_mtie, w_meie;
   logic [NUM_EXT-1:0]  w_ext_src, w_ext_req, w_complete_nxt;
   logic                w_ext_valid;
   logic [EXT_ID_W-1:0] w_ext_idx;
   logic                w_win, w_win_intr, w_win_ext;
   logic [CODE_W-1:0]   w_win_code;
   logic [XLEN-1:0]     w_base, w_win_cause, w_win_tval, w_win_vector, w_mstatus_nxt;
   trap_state_e         r_state, w_state_nxt;
   logic                w_snap, w_commit, w_mret_we;
   logic                w_unused;

   logic                r_trap_req, r_trap_taken, r_mstatus_we, r_is_ext;
   logic [XLEN-1:0]     r_cause, r_mepc, r_mtval, r_mstatus_new, r_vector;
   logic [EXT_ID_W-1:0] r_claim_id;
   logic [NUM_EXT-1:0]  r_complete;

   assign w_mie    = bus.csr_mstatus[MSTATUS_MIE];
   assign w_mpie   = bus.csr_mstatus[MSTATUS_MPIE];
   assign w_msie   = bus.csr_mie[MIE_MSIE];
   assign w_mtie   = bus.csr_mie[MIE_MTIE];
   assign w_meie   = bus.csr_mie[MIE_MEIE];
   assign w_unused = ^bus.csr_mie;

   assign w_complete_nxt = (w_commit && r_is_ext) ? (NUM_EXT'(1) << r_claim_id) : '0;

`ifdef TRAP_EDGE_IRQ_EN
   logic [NUM_EXT-1:0] r_irq_prev, r_pending, w_rise;

   assign w_rise    = bus.irq_ext & ~r_irq_prev;
   assign w_ext_src = r_pending | w_rise;

   // Sticky pending bits: a new rising edge beats the completion clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_prev <= '0;
         r_pending  <= '0;
      end else begin
         r_irq_prev <= bus.irq_ext;
         r_pending  <= (r_pending & ~w_complete_nxt) | w_rise;
      end
   end
`else
   assign w_ext_src = bus.irq_ext;
`endif

   assign w_ext_req = w_ext_src & {NUM_EXT{w_meie}};

   trap_prio_enc #(
      .N    (NUM_EXT),
      .ID_W (EXT_ID_W)
   ) u_prio_enc (
      .i_req   (w_ext_req),
      .o_valid (w_ext_valid),
      .o_idx   (w_ext_idx)
   );

   // Fixed-priority winner: exception, external, timer, software.
   always_comb begin
      w_win      = 1'b0;
      w_win_intr = 1'b0;
      w_win_ext  = 1'b0;
      w_win_code = '0;
      if (bus.exc_valid) begin
         w_win      = 1'b1;
         w_win_code = bus.exc_code;
      end else if (w_mie && w_ext_valid) begin
         w_win      = 1'b1;
         w_win_intr = 1'b1;
         w_win_ext  = 1'b1;
         w_win_code = CODE_W'(CAUSE_MEI);
      end else if (w_mie && w_mtie && bus.irq_mtip) begin
         w_win      = 1'b1;
         w_win_intr = 1'b1;
         w_win_code = CODE_W'(CAUSE_MTI);
      end else if (w_mie && w_msie && bus.irq_msip) begin
         w_win      = 1'b1;
         w_win_intr = 1'b1;
         w_win_code = CODE_W'(CAUSE_MSI);
      end
   end

   assign w_base       = {bus.csr_mtvec[XLEN-1:2], 2'b00};
   assign w_win_cause  = {w_win_intr, (XLEN-1)'(w_win_code)};
   assign w_win_tval   = w_win_intr ? '0 : bus.exc_tval;
   assign w_win_vector = (w_win_intr && (bus.csr_mtvec[1:0] == MTVEC_VECTORED))
                         ? w_base + XLEN'({w_win_code, 2'b00}) : w_base;

   // Trap entry stacks MIE into MPIE; mret restores MIE and sets MPIE.
   always_comb begin
      w_mstatus_nxt = bus.csr_mstatus;
      if (w_commit) begin
         w_mstatus_nxt[MSTATUS_MPIE] = w_mie;
         w_mstatus_nxt[MSTATUS_MIE]  = 1'b0;
      end else begin
         w_mstatus_nxt[MSTATUS_MIE]  = w_mpie;
         w_mstatus_nxt[MSTATUS_MPIE] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_snap      = 1'b0;
      w_commit    = 1'b0;
      w_mret_we   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_win) begin
               w_state_nxt = REQ;
               w_snap      = 1'b1;
            end else if (bus.mret) begin
               w_mret_we   = 1'b1;
            end
         end
         REQ: begin
            if (bus.trap_ack) begin
               w_state_nxt = COMMIT;
               w_commit    = 1'b1;
            end
         end
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered outputs; the snapshot holds until the next trap is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trap_req    <= 1'b0;
         r_trap_taken  <= 1'b0;
         r_mstatus_we  <= 1'b0;
         r_mstatus_new <= '0;
         r_complete    <= '0;
         r_cause       <= '0;
         r_mepc        <= '0;
         r_mtval       <= '0;
         r_vector      <= '0;
         r_claim_id    <= '0;
         r_is_ext      <= 1'b0;
      end else begin
         r_trap_req   <= (w_state_nxt == REQ);
         r_trap_taken <= w_commit;
         r_mstatus_we <= w_commit | w_mret_we;
         r_complete   <= w_complete_nxt;
         if (w_commit || w_mret_we) r_mstatus_new <= w_mstatus_nxt;
         if (w_snap) begin
            r_cause    <= w_win_cause;
            r_mepc     <= bus.current_pc;
            r_mtval    <= w_win_tval;
            r_vector   <= w_win_vector;
            r_claim_id <= w_win_ext ? w_ext_idx : '0;
            r_is_ext   <= w_win_ext;
         end
      end
   end

   assign bus.trap_req         = r_trap_req;
   assign bus.trap_taken       = r_trap_taken;
   assign bus.mstatus_we       = r_mstatus_we;
   assign bus.trap_mstatus_new = r_mstatus_new;
   assign bus.trap_cause       = r_cause;
   assign bus.trap_mepc        = r_mepc;
   assign bus.trap_mtval       = r_mtval;
   assign bus.trap_vector      = r_vector;
   assign bus.ext_claim_id     = r_claim_id;
   assign bus.irq_ext_complete = r_complete;

endmodule

// File: tb/tb_trap_ctrl_vec.sv
// Bench for trap_ctrl_vec: directed scenarios then random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_trap_ctrl_vec;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned NUM_EXT  = 4;
   localparam int unsigned EXT_ID_W = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   trap_ctrl_vec_if #(.XLEN(XLEN), .NUM_EXT(NUM_EXT), .EXT_ID_W(EXT_ID_W)) bus ();

   trap_ctrl_vec #(.XLEN(XLEN), .NUM_EXT(NUM_EXT), .EXT_ID_W(EXT_ID_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
   endtask

   // Reference model: a trap is "in flight" from acceptance until acked.
   int                  m_phase;   // 0 idle, 1 awaiting ack, 2 commit cycle
   bit                  m_is_ext;
   bit [NUM_EXT-1:0]    m_pend, m_prev;
   bit                  e_req, e_taken, e_we;
   bit [XLEN-1:0]       e_cause, e_mepc, e_mtval, e_mst_new, e_vec;
   bit [EXT_ID_W-1:0]   e_id;
   bit [NUM_EXT-1:0]    e_cmpl;

   function automatic bit [31:0] enter_mstatus(bit [31:0] ms);
      return (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
   endfunction

   function automatic bit [31:0] mret_mstatus(bit [31:0] ms);
      return (ms & ~32'h8) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_is_ext = 0; m_pend = '0; m_prev = '0;
      e_req = 0; e_taken = 0; e_we = 0; e_cause = '0; e_mepc = '0; e_mtval = '0;
      e_mst_new = '0; e_vec = '0; e_id = '0; e_cmpl = '0;
   endtask

   task automatic model_step();
      bit [NUM_EXT-1:0] src, rise;
      int  first, code;
      bit  found, intr;
      rise = bus.irq_ext & ~m_prev;
`ifdef TRAP_EDGE_IRQ_EN
      src = m_pend | rise;
`else
      src = bus.irq_ext;
`endif
      e_taken = 0; e_we = 0; e_cmpl = '0;
      if (m_phase == 0) begin
         found = 0; intr = 1; code = 0; first = -1;
         for (int i = 0; i < int'(NUM_EXT); i++) if (first < 0 && src[i]) first = i;
         if (bus.exc_valid) begin
            found = 1; intr = 0; code = int'(bus.exc_code);
         end else if (bus.csr_mstatus[3] && bus.csr_mie[11] && first >= 0) begin
            found = 1; code = 11;
         end else if (bus.csr_mstatus[3] && bus.csr_mie[7] && bus.irq_mtip) begin
            found = 1; code = 7;
         end else if (bus.csr_mstatus[3] && bus.csr_mie[3] && bus.irq_msip) begin
            found = 1; code = 3;
         end
         if (found) begin
            e_cause  = intr ? (32'h8000_0000 | 32'(code)) : 32'(code);
            e_mepc   = bus.current_pc;
            e_mtval  = intr ? 32'h0 : bus.exc_tval;
            e_vec    = (bus.csr_mtvec & ~32'h3)
                       + ((intr && bus.csr_mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
            m_is_ext = intr && (code == 11);
            e_id     = m_is_ext ? EXT_ID_W'(first) : '0;
            m_phase  = 1;
         end else if (bus.mret) begin
            e_we = 1; e_mst_new = mret_mstatus(bus.csr_mstatus);
         end
      end else if (m_phase == 1) begin
         if (bus.trap_ack) begin
            m_phase = 2; e_taken = 1; e_we = 1;
            e_mst_new = enter_mstatus(bus.csr_mstatus);
            if (m_is_ext) e_cmpl = NUM_EXT'(1) << e_id;
         end
      end else begin
         m_phase = 0;
      end
      e_req  = (m_phase == 1);
      m_pend = (m_pend & ~e_cmpl) | rise;
      m_prev = bus.irq_ext;
   endtask

   task automatic compare_all();
      check_eq("trap_req",         64'(bus.trap_req),         64'(e_req));
      check_eq("trap_taken",       64'(bus.trap_taken),       64'(e_taken));
      check_eq("mstatus_we",       64'(bus.mstatus_we),       64'(e_we));
      check_eq("trap_cause",       64'(bus.trap_cause),       64'(e_cause));
      check_eq("trap_mepc",        64'(bus.trap_mepc),        64'(e_mepc));
      check_eq("trap_mtval",       64'(bus.trap_mtval),       64'(e_mtval));
      check_eq("trap_vector",      64'(bus.trap_vector),      64'(e_vec));
      check_eq("ext_claim_id",     64'(bus.ext_claim_id),     64'(e_id));
      check_eq("irq_ext_complete", 64'(bus.irq_ext_complete), 64'(e_cmpl));
      if (e_we) check_eq("trap_mstatus_new", 64'(bus.trap_mstatus_new), 64'(e_mst_new));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      bus.current_pc = 32'h0000_4000; bus.csr_mstatus = '0; bus.csr_mie = '0;
      bus.csr_mtvec = 32'h0000_1001; bus.irq_msip = 0; bus.irq_mtip = 0;
      bus.irq_ext = '0; bus.exc_valid = 0; bus.exc_code = '0; bus.exc_tval = '0;
      bus.mret = 0; bus.trap_ack = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check_eq("rst_req", 64'(bus.trap_req), 64'h0);
      rst_n = 1'b1;

      // Vectored external interrupt, lowest set line wins, ack two cycles later
      bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h800; bus.irq_ext = 4'b0110;
      cycle();
      check_eq("t1_req",    64'(bus.trap_req),     64'h1);
      check_eq("t1_cause",  64'(bus.trap_cause),   64'h8000_000B);
      check_eq("t1_id",     64'(bus.ext_claim_id), 64'h1);
      check_eq("t1_vector", 64'(bus.trap_vector),  64'h102C);
      cycle();
      bus.trap_ack = 1;
      cycle();
      check_eq("t1_taken",   64'(bus.trap_taken),       64'h1);
      check_eq("t1_cmpl",    64'(bus.irq_ext_complete), 64'h2);
      check_eq("t1_mst_new", 64'(bus.trap_mstatus_new), 64'h80);
      bus.trap_ack = 0; bus.irq_ext = '0;
      cycle();

      // Exception beats a pending timer interrupt; vector stays at base
      bus.csr_mie = 32'h80; bus.irq_mtip = 1;
      bus.exc_valid = 1; bus.exc_code = 5'd2; bus.exc_tval = 32'hDEAD_BEEF;
      cycle();
      check_eq("t2_cause",  64'(bus.trap_cause),  64'h2);
      check_eq("t2_mtval",  64'(bus.trap_mtval),  64'hDEAD_BEEF);
      check_eq("t2_vector", 64'(bus.trap_vector), 64'h1000);
      bus.trap_ack = 1;
      cycle();
      bus.trap_ack = 0; bus.exc_valid = 0; bus.irq_mtip = 0;
      cycle();

      // Timer masked by MIE=0, then taken one cycle after MIE rises
      bus.csr_mstatus = 32'h0; bus.irq_mtip = 1;
      cycle();
      check_eq("t3_masked_a", 64'(bus.trap_req), 64'h0);
      cycle();
      check_eq("t3_masked_b", 64'(bus.trap_req), 64'h0);
      bus.csr_mstatus = 32'h8;
      cycle();
      check_eq("t3_req",   64'(bus.trap_req),   64'h1);
      check_eq("t3_cause", 64'(bus.trap_cause), 64'h8000_0007);
      bus.trap_ack = 1;
      cycle();
      bus.trap_ack = 0; bus.irq_mtip = 0;
      cycle();

      // mret in idle
      bus.csr_mstatus = 32'h80; bus.mret = 1;
      cycle();
      check_eq("t4_we",      64'(bus.mstatus_we),       64'h1);
      check_eq("t4_mst_new", 64'(bus.trap_mstatus_new), 64'h88);
      bus.mret = 0;
      cycle();
      check_eq("t4_we_low", 64'(bus.mstatus_we), 64'h0);

      // Reset while a trap request is outstanding
      bus.csr_mstatus = 32'h8; bus.irq_mtip = 1;
      cycle();
      check_eq("t5_req_before", 64'(bus.trap_req), 64'h1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      check_eq("t5_req_rst",   64'(bus.trap_req),   64'h0);
      check_eq("t5_cause_rst", 64'(bus.trap_cause), 64'h0);
      bus.irq_mtip = 0; bus.trap_ack = 1;
      cycle();
      bus.trap_ack = 0; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("t5_no_taken", 64'(bus.trap_taken), 64'h0);
      end

`ifdef TRAP_EDGE_IRQ_EN
      // Short external pulse during a timer request is remembered
      bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h880; bus.irq_mtip = 1;
      cycle();
      check_eq("t6_cause_a", 64'(bus.trap_cause), 64'h8000_0007);
      bus.irq_ext = 4'b1000;
      cycle();
      bus.irq_ext = '0; bus.trap_ack = 1;
      cycle();
      check_eq("t6_taken_a", 64'(bus.trap_taken), 64'h1);
      bus.irq_mtip = 0; bus.trap_ack = 0;
      cycle();
      cycle();
      check_eq("t6_req_b",   64'(bus.trap_req),     64'h1);
      check_eq("t6_cause_b", 64'(bus.trap_cause),   64'h8000_000B);
      check_eq("t6_id_b",    64'(bus.ext_claim_id), 64'h3);
      bus.trap_ack = 1;
      cycle();
      check_eq("t6_cmpl_b", 64'(bus.irq_ext_complete), 64'h8);
      bus.trap_ack = 0;
      cycle();
`endif

      // Random traffic; exceptions are held until their own trap is taken
      clear_inputs();
      for (int n = 0; n < 3000; n++) begin
         if (bus.exc_valid && e_taken && !e_cause[31]) bus.exc_valid = 0;
         if (!bus.exc_valid && $urandom_range(0, 19) == 0) begin
            bus.exc_valid = 1;
            bus.exc_code  = 5'($urandom);
            bus.exc_tval  = $urandom;
         end
         bus.current_pc  = $urandom;
         bus.csr_mstatus = $urandom;
         bus.csr_mie     = $urandom;
         bus.csr_mtvec   = $urandom;
         bus.mret        = ($urandom_range(0, 11) == 0);
         bus.trap_ack    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) bus.irq_mtip = ~bus.irq_mtip;
         if ($urandom_range(0, 7) == 0) bus.irq_msip = ~bus.irq_msip;
         bus.irq_ext = bus.irq_ext ^ (NUM_EXT'($urandom) & NUM_EXT'($urandom) & NUM_EXT'($urandom));
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            bus.exc_valid = 0;
            model_reset();
            #1;
            compare_all();
         end else begin
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
